bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
Read-side engine for the single-port 1024x32 block RAM, which has a combinational read port. On a start pulse it walks a contiguous address range, with wrap-around, and emits each word on a valid/ready stream with backpressure. It sits between the BRAM and any downstream consumer, such as a UART TX or processing pipeline. It owns the BRAM address bus while busy and never writes the memory.

Parameters:
ADDR_W, 10, BRAM address width; depth = 2**ADDR_W.
DATA_W, 32, BRAM word width and stream data width.

Ports:
clk  in  1  system clock; all state updates on posedge clk.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request; sampled only in IDLE.
start_addr  in  ADDR_W  first word address.
length  in  ADDR_W+1  number of words, 0..2**ADDR_W.
abort  in  1  cancel the current transfer.
mem_addr  out  ADDR_W  address to the BRAM read port.
mem_dout  in  DATA_W  BRAM combinational read data for mem_addr.
m_valid  out  1  stream word valid.
m_data  out  DATA_W  stream word.
m_last  out  1  marks the final word of a transfer.
m_ready  in  1  downstream accept.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (async, rst=1) values: state=IDLE, mem_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, remaining=0.
- State machine has two states: IDLE and RUN.
- IDLE + start + length!=0:
  - mem_addr<=start_addr, remaining<=length, state<=RUN.
  - busy rises next cycle.
- IDLE + start + length==0: no transfer; done pulses the next cycle and state stays IDLE.
- start while in RUN is ignored; there is no queueing.
- RUN fetch rule: let load = (remaining!=0) && (!m_valid || m_ready). On load:
  - m_data<=mem_dout, m_valid<=1, m_last<=(remaining==1).
  - mem_addr<=mem_addr+1, mod 2**ADDR_W; 1023 wraps to 0.
  - remaining<=remaining-1.
- Stream handshake:
  - A beat transfers when m_valid && m_ready.
  - Without load, m_valid clears on a transfer.
  - While m_valid=1 && m_ready=0, m_data and m_last hold stable.
- Latency and throughput:
  - start at edge N -> RUN at N+1 -> first m_valid at edge N+2.
  - With m_ready held high, one word per cycle.
- Completion: the edge that transfers the beat with m_last=1 sets state<=IDLE, m_valid<=0, m_last<=0, done<=1 for exactly one cycle.
- length==2**ADDR_W reads the whole memory once, ending at start_addr-1 after wrapping.
- abort in RUN:
  - Next edge: state<=IDLE, m_valid<=0, m_last<=0, remaining<=0.
  - No done pulse; a beat transferred in the abort cycle counts as delivered.
  - abort in IDLE is ignored; abort wins over a simultaneous start in IDLE.
- Reset mid-transfer drops everything immediately (async); no partial-state recovery.
- mem_addr holds its last value in IDLE; the BRAM write port is driven elsewhere only while busy=0.

Decomposition:
- A shared package or include carries the state encoding (ST_IDLE=1'b0, ST_RUN=1'b1) and the BRAM geometry constants (ADDR_W=10, DATA_W=32, DEPTH=1024), reused by the BRAM and its writer.
- One natural sub-module: bram_stream_out_reg, the output holding register containing the load/valid/last logic.
- The FSM and address counter stay in the top module.

Test Plan:
1. Preload mem[k]=k+0x100. Issue start, start_addr=5, length=4, m_ready=1 -> m_data 0x105,0x106,0x107,0x108 on consecutive cycles from edge N+2; m_last on 0x108; done one cycle later; busy low.
2. Same transfer, with m_ready toggling 1,0,0,1,0,1 -> no word lost or duplicated; m_data/m_last stable while stalled; the four words arrive in order.
3. Issue start_addr=1022, length=4 -> words from addresses 1022,1023,0,1; mem_addr wraps to 0.
4. Issue length=0 -> done pulses once; m_valid never rises; busy stays 0. Then issue length=1024 from addr 0 -> 1024 beats, m_last only on the beat for address 1023.
5. Abort after 2 of 8 beats accepted -> m_valid=0 the next cycle, no done, state IDLE. A new start then succeeds with correct data.
6. Assert rst asynchronously mid-transfer with m_valid=1 -> m_valid, busy, and done drop without waiting for clk; all outputs at reset values.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// Shared BRAM geometry and reader state encoding, reused by the BRAM, its
// writer and the stream reader.
package bram_stream_reader_pkg;

   localparam int BRAM_ADDR_W = 10;
   localparam int BRAM_DATA_W = 32;
   localparam int BRAM_DEPTH  = 1024;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/bram_stream_out_reg.sv
// Output holding register of the stream reader: captures a BRAM word on load
// and holds it, with its last flag, until the consumer accepts it.
module bram_stream_out_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic              last_in,
   input  logic              ready,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid,
   output logic              last,
   output logic [DATA_W-1:0] data
);

   // Holding register; clear (abort or final beat) takes priority over a new load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         last  <= 1'b0;
         data  <= {DATA_W{1'b0}};
      end else if (clear) begin
         valid <= 1'b0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         last  <= last_in;
         data  <= data_in;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side engine for the block RAM: walks a wrapping address range on start
// and streams each word out on a valid/ready interface with backpressure.
module bram_stream_reader #(
   parameter int ADDR_W = bram_stream_reader_pkg::BRAM_ADDR_W,
   parameter int DATA_W = bram_stream_reader_pkg::BRAM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              abort,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic              done
);

   import bram_stream_reader_pkg::*;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W:0]   remaining_nx;
   logic              done_nx;
   logic              load;
   logic              clear;
   logic              final_beat;

   assign final_beat = m_valid && m_ready && m_last;
   assign load  = (state == ST_RUN) && !abort && (remaining != {(ADDR_W+1){1'b0}})
                  && (!m_valid || m_ready);
   assign clear = (state == ST_RUN) && (abort || final_beat);
   assign busy  = (state == ST_RUN);

   // Next-state, address counter and word countdown.
   always_comb begin
      state_nx     = state;
      mem_addr_nx  = mem_addr;
      remaining_nx = remaining;
      done_nx      = 1'b0;
      case (state)
         ST_IDLE: begin
            // abort beats a simultaneous start; a zero-length start only pulses done
            if (start && !abort) begin
               if (length != {(ADDR_W+1){1'b0}}) begin
                  state_nx     = ST_RUN;
                  mem_addr_nx  = start_addr;
                  remaining_nx = length;
               end else begin
                  done_nx = 1'b1;
               end
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nx     = ST_IDLE;
               remaining_nx = {(ADDR_W+1){1'b0}};
            end else if (final_beat) begin
               state_nx = ST_IDLE;
               done_nx  = 1'b1;
            end else if (load) begin
               mem_addr_nx  = mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
               remaining_nx = remaining - {{ADDR_W{1'b0}}, 1'b1};
            end else begin
               state_nx = ST_RUN;
            end
         end
         default: begin
            state_nx     = ST_IDLE;
            remaining_nx = {(ADDR_W+1){1'b0}};
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         mem_addr  <= {ADDR_W{1'b0}};
         remaining <= {(ADDR_W+1){1'b0}};
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         mem_addr  <= mem_addr_nx;
         remaining <= remaining_nx;
         done      <= done_nx;
      end
   end

   bram_stream_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .clear   (clear),
      .last_in (remaining == {{ADDR_W{1'b0}}, 1'b1}),
      .ready   (m_ready),
      .data_in (mem_dout),
      .valid   (m_valid),
      .last    (m_last),
      .data    (m_data)
   );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: directed table, hand-written
// corner sequences and randomized transfers against a queue-based model.
module tb_bram_stream_reader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  start_addr;
   logic [10:0] length;
   logic        abort;
   logic [9:0]  mem_addr;
   logic [31:0] mem_dout;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_last;
   logic        m_ready;
   logic        busy;
   logic        done;

   logic [31:0] mem [0:1023];
   assign mem_dout = mem[mem_addr];

   bram_stream_reader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .length     (length),
      .abort      (abort),
      .mem_addr   (mem_addr),
      .mem_dout   (mem_dout),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_last     (m_last),
      .m_ready    (m_ready),
      .busy       (busy),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [9:0]  sa;
      logic [10:0] len;
      int          pct;
      logic [31:0] first;
      logic [31:0] lastw;
      int          beats;
      logic [9:0]  end_addr;
   } vec_t;

   vec_t        vecs [8];
   int          pat [16] = '{1,1,1,0,0,1,0,1,1,1,1,1,1,1,1,1};
   int          tests = 0;
   int          fails = 0;
   logic [32:0] expq [$];
   int          xfer_beats;
   int          dones;
   logic [31:0] first_word;
   logic [31:0] last_word;
   bit          prev_stall = 1'b0;
   bit          prev_abort = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;
   logic [9:0]  model_addr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard sampling, called once per cycle away from the clock edge.
   task automatic sample();
      logic [32:0] e;
      if (!rst) begin
         if (prev_stall && !prev_abort)
            check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_beat: got data %0h with no word expected", m_data);
            end else begin
               e = expq.pop_front();
               check("beat", {m_last, m_data}, e);
            end
            if (xfer_beats == 0) first_word = m_data;
            if (m_last) last_word = m_data;
            xfer_beats++;
         end
         if (done) dones++;
         prev_stall = m_valid && !m_ready;
         prev_abort = abort;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ready_val(input int pct, input int n);
      if (pct < 0) return (pat[n % 16] != 0);
      return ($urandom_range(0, 99) < pct);
   endfunction

   // Reference: a transfer yields words at (sa+i) mod depth, last on the final one.
   task automatic model_push(input int sa, input int len);
      for (int i = 0; i < len; i++)
         expq.push_back({(i == len - 1), mem[(sa + i) % 1024]});
   endtask

   task automatic run_xfer(input int sa, input int len, input int pct);
      int n;
      int budget;
      budget = len * 20 + 40;
      model_push(sa, len);
      xfer_beats = 0;
      dones      = 0;
      first_word = 32'h0;
      last_word  = 32'h0;
      start      = 1'b1;
      start_addr = sa[9:0];
      length     = len[10:0];
      m_ready    = ready_val(pct, 0);
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < budget) begin
         n++;
         m_ready = ready_val(pct, n);
         tick();
      end
      check("done_seen", done, 1'b1);
      check("busy_after", busy, 1'b0);
      check("valid_after", m_valid, 1'b0);
      check("queue_empty", expq.size(), 0);
      tick();
      check("done_single", done, 1'b0);
      check("done_count", dones, 1);
      expq.delete();
   endtask

   initial begin
      logic [9:0]  sa;
      int          len;
      int          r;
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = 10'd0;
      length     = 11'd0;
      abort      = 1'b0;
      m_ready    = 1'b0;
      for (int k = 0; k < 1024; k++) mem[k] = k + 32'h100;
      #12;
      check("rst_mem_addr", mem_addr, 10'd0);
      check("rst_valid", m_valid, 1'b0);
      check("rst_data", m_data, 32'h0);
      check("rst_last", m_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Latency: RUN one edge after start, first word one edge later.
      model_push(5, 4);
      xfer_beats = 0;
      dones      = 0;
      m_ready    = 1'b1;
      start      = 1'b1;
      start_addr = 10'd5;
      length     = 11'd4;
      tick();
      start = 1'b0;
      check("lat_busy", busy, 1'b1);
      check("lat_valid0", m_valid, 1'b0);
      check("lat_addr0", mem_addr, 10'd5);
      tick();
      check("lat_valid1", m_valid, 1'b1);
      check("lat_data1", m_data, 32'h105);
      check("lat_last1", m_last, 1'b0);
      tick();
      tick();
      tick();
      check("lat_data4", m_data, 32'h108);
      check("lat_last4", m_last, 1'b1);
      tick();
      check("lat_done", done, 1'b1);
      check("lat_idle", busy, 1'b0);
      check("lat_valid_off", m_valid, 1'b0);
      tick();
      check("lat_done_off", done, 1'b0);
      check("lat_beats", xfer_beats, 4);
      check("lat_dones", dones, 1);
      expq.delete();

      vecs[0] = '{10'd5,    11'd4,    100, 32'h105, 32'h108, 4,    10'd9};
      vecs[1] = '{10'd5,    11'd4,    -1,  32'h105, 32'h108, 4,    10'd9};
      vecs[2] = '{10'd5,    11'd4,    40,  32'h105, 32'h108, 4,    10'd9};
      vecs[3] = '{10'd1022, 11'd4,    100, 32'h4FE, 32'h101, 4,    10'd2};
      vecs[4] = '{10'd0,    11'd0,    100, 32'h0,   32'h0,   0,    10'd2};
      vecs[5] = '{10'd0,    11'd1024, 100, 32'h100, 32'h4FF, 1024, 10'd0};
      vecs[6] = '{10'd1023, 11'd1,    50,  32'h4FF, 32'h4FF, 1,    10'd0};
      vecs[7] = '{10'd100,  11'd1024, 80,  32'h164, 32'h163, 1024, 10'd100};
      for (int i = 0; i < 8; i++) begin
         run_xfer(int'(vecs[i].sa), int'(vecs[i].len), vecs[i].pct);
         check("vec_beats", xfer_beats, vecs[i].beats);
         check("vec_end_addr", mem_addr, vecs[i].end_addr);
         if (vecs[i].beats != 0) begin
            check("vec_first", first_word, vecs[i].first);
            check("vec_last", last_word, vecs[i].lastw);
         end
         model_addr = vecs[i].end_addr;
      end

      // Randomized transfers over random memory contents.
      for (int it = 0; it < 15; it++) begin
         for (int k = 0; k < 1024; k++) mem[k] = $urandom;
         sa = 10'($urandom_range(0, 1023));
         r  = $urandom_range(0, 9);
         len = (r == 0) ? 0 : (r == 1) ? 1024 : $urandom_range(1, 40);
         run_xfer(int'(sa), len, $urandom_range(25, 100));
         if (len != 0) model_addr = 10'((int'(sa) + len) % 1024);
         check("rnd_end_addr", mem_addr, model_addr);
         check("rnd_beats", xfer_beats, len);
      end

      // Abort after two of eight beats accepted.
      for (int k = 0; k < 1024; k++) mem[k] = k + 32'h100;
      model_push(10, 8);
      xfer_beats = 0;
      dones      = 0;
      m_ready    = 1'b0;
      start      = 1'b1;
      start_addr = 10'd10;
      length     = 11'd8;
      tick();
      start = 1'b0;
      tick();
      m_ready = 1'b1;
      tick();
      tick();
      m_ready = 1'b0;
      abort   = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_valid", m_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_beats", xfer_beats, 2);
      expq.delete();
      tick();
      tick();
      check("abort_no_done", dones, 0);
      run_xfer(200, 3, 100);
      check("post_abort_first", first_word, 32'h1C8);
      check("post_abort_last", last_word, 32'h1CA);

      // abort wins over start in IDLE.
      dones = 0;
      start = 1'b1;
      abort = 1'b1;
      start_addr = 10'd3;
      length     = 11'd5;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("idle_abort_busy", busy, 1'b0);
      tick();
      check("idle_abort_done", dones, 0);

      // Asynchronous reset mid-transfer.
      m_ready    = 1'b0;
      start      = 1'b1;
      start_addr = 10'd0;
      length     = 11'd8;
      tick();
      start = 1'b0;
      tick();
      check("prerst_valid", m_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", m_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_last", m_last, 1'b0);
      check("arst_data", m_data, 32'h0);
      check("arst_addr", mem_addr, 10'd0);
      expq.delete();
      prev_stall = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_valid", m_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
